// File: rtl/vend_change_dispenser.sv
// rtl/vend_change_dispenser.sv - greedy coin-return payout sequencer for the change hopper
//
// Pays out I_AMOUNT cents largest-coin-first (500,100,25,10,5,1), one coin per
// valid/ack handshake. Empty tubes are skipped; a tube that does not ack within
// ACK_TIMEOUT cycles is retired (jammed) until the next transaction.
//
// Ports:
//   I_CLK        clock, rising edge
//   I_RESET_N    asynchronous active-low reset
//   I_START      begin payout of I_AMOUNT (only looked at while idle)
//   I_AMOUNT     change to dispense in cents, captured with an accepted start
//   I_EMPTY      per-tube empty flags, bit index = coin code
//   I_EJECT_ACK  hopper released the requested coin
//   O_EJECT      coin request valid
//   O_COIN       coin code 0=500 1=100 2=25 3=10 4=5 5=1, stable while O_EJECT=1
//   O_BUSY       high whenever not idle
//   O_DONE       one-cycle end-of-transaction pulse
//   O_SHORT      cents left unpaid, valid from O_DONE until the next start
//   O_COINS      coins ejected in the last transaction, saturating
//   O_FAULT      some tube timed out in the last transaction
module vend_change_dispenser #(
  parameter int ACK_TIMEOUT = 1000,
  parameter int AMT_W       = 16
) (
  input  logic             I_CLK,
  input  logic             I_RESET_N,
  input  logic             I_START,
  input  logic [AMT_W-1:0] I_AMOUNT,
  input  logic [5:0]       I_EMPTY,
  input  logic             I_EJECT_ACK,
  output logic             O_EJECT,
  output logic [2:0]       O_COIN,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic [AMT_W-1:0] O_SHORT,
  output logic [15:0]      O_COINS,
  output logic             O_FAULT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_EJECT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t           state_q,  state_d;
  logic [AMT_W-1:0] remain_q, remain_d;
  logic [5:0]       jam_q,    jam_d;
  logic [15:0]      tmo_q,    tmo_d;
  logic             eject_q,  eject_d;
  logic [2:0]       coin_q,   coin_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [AMT_W-1:0] short_q,  short_d;
  logic [15:0]      coins_q,  coins_d;
  logic             fault_q,  fault_d;

  logic             sel_found;
  logic [2:0]       sel_code;
  logic [31:0]      rem_ext;
  logic [AMT_W-1:0] remain_after;

  function automatic logic [31:0] coin_value(input logic [2:0] code);
    case (code)
      3'd0:    coin_value = 32'd500;
      3'd1:    coin_value = 32'd100;
      3'd2:    coin_value = 32'd25;
      3'd3:    coin_value = 32'd10;
      3'd4:    coin_value = 32'd5;
      3'd5:    coin_value = 32'd1;
      default: coin_value = 32'd0;
    endcase
  endfunction

  // Compare in 32 bits so a narrow AMT_W still ranks large coins correctly.
  assign rem_ext = 32'(remain_q);

  // Selection only ever picks a coin not larger than the remainder, so this
  // subtraction cannot wrap.
  assign remain_after = AMT_W'(rem_ext - coin_value(coin_q));

  // Lowest usable code = largest usable denomination. Scanning downward lets
  // the last hit win, which is the lowest index.
  always_comb begin
    sel_found = 1'b0;
    sel_code  = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (!I_EMPTY[i] && !jam_q[i] && (coin_value(3'(i)) <= rem_ext)) begin
        sel_found = 1'b1;
        sel_code  = 3'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    jam_d    = jam_q;
    tmo_d    = tmo_q;
    eject_d  = eject_q;
    coin_d   = coin_q;
    short_d  = short_q;
    coins_d  = coins_q;
    fault_d  = fault_q;

    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          remain_d = I_AMOUNT;
          coins_d  = 16'd0;
          fault_d  = 1'b0;
          jam_d    = 6'd0;
          short_d  = '0;
          state_d  = (I_AMOUNT == '0) ? S_DONE : S_SELECT;
        end
      end

      S_SELECT: begin
        if (sel_found) begin
          coin_d  = sel_code;
          eject_d = 1'b1;
          tmo_d   = 16'd0;
          state_d = S_EJECT;
        end else begin
          short_d = remain_q;
          state_d = S_DONE;
        end
      end

      S_EJECT: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (I_EJECT_ACK) begin
          eject_d  = 1'b0;
          remain_d = remain_after;
          coins_d  = (coins_q == 16'hFFFF) ? coins_q : coins_q + 16'd1;
          if (remain_after == '0) begin
            short_d = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_SELECT;
          end
        end else if (tmo_q == TMO_LAST) begin
          eject_d = 1'b0;
          jam_d   = jam_q | (6'b000001 << coin_q);
          fault_d = 1'b1;
          state_d = S_SELECT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs follow the next state so they line up with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      jam_q    <= 6'd0;
      tmo_q    <= 16'd0;
      eject_q  <= 1'b0;
      coin_q   <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= '0;
      coins_q  <= 16'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      jam_q    <= jam_d;
      tmo_q    <= tmo_d;
      eject_q  <= eject_d;
      coin_q   <= coin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      short_q  <= short_d;
      coins_q  <= coins_d;
      fault_q  <= fault_d;
    end
  end

  assign O_EJECT = eject_q;
  assign O_COIN  = coin_q;
  assign O_BUSY  = busy_q;
  assign O_DONE  = done_q;
  assign O_SHORT = short_q;
  assign O_COINS = coins_q;
  assign O_FAULT = fault_q;

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
- Sequencing controller for the coin-return hopper of the vending machine.
- On a start request it takes a change amount in cents and pays it out greedily, largest denomination first (500, 100, 25, 10, 5, 1).
- Each coin is issued to the hopper over a valid/ack handshake. Empty tubes are skipped, and a jammed tube (no ack within a timeout) is retired for the rest of the transaction.
- It reports completion, any unpaid shortfall and the coin count to the vending FSM.

Parameters:
- ACK_TIMEOUT, 1000, cycles O_EJECT may wait for I_EJECT_ACK before the tube is declared jammed (1..65535).
- AMT_W, 16, width of the amount, remainder and shortfall datapath.

Ports:
- I_CLK  in  1  clock; all state changes on the rising edge.
- I_RESET_N  in  1  asynchronous active-low reset.
- I_START  in  1  pulse or level: begin payout of I_AMOUNT; sampled only in IDLE.
- I_AMOUNT  in  AMT_W  change to dispense, in cents; captured on the accepted start.
- I_EMPTY  in  6  per-tube empty flag; bit index = coin code; sampled in SELECT.
- I_EJECT_ACK  in  1  hopper has released the requested coin.
- O_EJECT  out  1  coin request valid.
- O_COIN  out  3  coin code: 0=500, 1=100, 2=25, 3=10, 4=5, 5=1; stable while O_EJECT=1.
- O_BUSY  out  1  high in every state except IDLE.
- O_DONE  out  1  one-cycle pulse at end of transaction.
- O_SHORT  out  AMT_W  cents not paid; valid from O_DONE until the next accepted start.
- O_COINS  out  16  coins ejected in the last transaction; saturates at 65535.
- O_FAULT  out  1  at least one tube timed out in the last transaction.

Behaviour:
- Reset: async on I_RESET_N=0.
  - State returns to IDLE; all outputs 0; remainder 0; jam mask 0; timeout counter 0.
  - Reset mid-transaction abandons it; no O_DONE pulse is produced.
- States: IDLE, SELECT, EJECT, DONE. All outputs are registered.
- IDLE:
  - On I_START=1: remain <= I_AMOUNT; O_COINS, O_FAULT and jam mask cleared; O_SHORT <= 0.
  - Next state is DONE if I_AMOUNT==0, otherwise SELECT.
  - I_START in any other state is ignored; there is no queueing.
- SELECT (exactly one cycle):
  - Choose the lowest code c with value(c) <= remain, I_EMPTY[c]==0 and jam[c]==0.
  - If found: O_COIN <= c, O_EJECT <= 1, timeout counter <= 0, go to EJECT.
  - If none: O_SHORT <= remain, go to DONE.
- EJECT:
  - O_EJECT stays 1 and O_COIN stays unchanged until the exit condition below.
  - I_EJECT_ACK=1 sampled:
    - O_EJECT <= 0; remain <= remain - value(O_COIN); O_COINS increments (saturating).
    - Go to DONE with O_SHORT=0 if the new remain is 0, else go to SELECT.
  - Counter reaches ACK_TIMEOUT-1 with no ack:
    - O_EJECT <= 0; jam[O_COIN] <= 1; O_FAULT <= 1; remain unchanged; go to SELECT.
  - Ack on the same cycle as the timeout: the ack wins and no jam is recorded.
  - I_EJECT_ACK while O_EJECT=0 is ignored.
- DONE: O_DONE=1 for one cycle, then IDLE.
- Subtraction never underflows, because selection guarantees value(c) <= remain.
- I_EMPTY changing during EJECT does not affect the coin in flight.

Latency:
- Start accepted at edge t0 → SELECT after t0 → O_EJECT=1 after t1.
- Best-case per coin (ack held high): 2 cycles (EJECT, SELECT).
- Final-coin ack edge → O_DONE high in the next cycle.

Test Plan:
- I_AMOUNT=641, I_EMPTY=0, ack one cycle after each O_EJECT → codes 0,1,2,3,4,5 in order; O_SHORT=0, O_COINS=6, O_FAULT=0, single O_DONE pulse.
- I_AMOUNT=200, I_EMPTY=6'b000010 (100s empty) → eight code-2 ejects; O_SHORT=0, O_COINS=8.
- I_AMOUNT=3, I_EMPTY=6'b100000 → no O_EJECT; O_DONE two cycles after start; O_SHORT=3, O_COINS=0. I_AMOUNT=0 → O_DONE with no ejects.
- ACK_TIMEOUT=4, I_AMOUNT=100, code-1 never acked → O_EJECT drops after 4 cycles, then four code-2 ejects; O_FAULT=1, O_SHORT=0.
- I_RESET_N low during EJECT of a 500 coin → all outputs 0 immediately, no O_DONE. After release, a new start with 25 → one code-2 eject. A second I_START during BUSY is ignored.
